// File: rtl/cmd_pkg.sv
// Shared definitions for the command scheduler: FSM encoding and default timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    // Default idle guard between commands and per-wait-state abort limit.
    localparam int DEF_GAP_CYCLES = 5;
    localparam int DEF_TIMEOUT    = 1000;

    // The gap counter is fixed-width so any GAP_CYCLES up to 2^25-1 fits.
    localparam int GAP_CNT_W = 25;

endpackage

// File: rtl/cmd_scheduler_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr (wrapping) wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to accept the winner.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  winner,
    output logic [IDX_W-1:0] idx
);

    // One extra bit so ptr+i cannot overflow before the wrap subtraction.
    localparam int JW = IDX_W + 1;

    logic [JW-1:0] j;
    logic          found;

    // Scan requesters in priority order starting at ptr; keep the first hit.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        j      = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = {1'b0, ptr} + JW'(i);
            if (j >= JW'(NREQ)) begin
                j = j - JW'(NREQ);
            end
            if (!found && req[j[IDX_W-1:0]]) begin
                found                 = 1'b1;
                winner[j[IDX_W-1:0]]  = 1'b1;
                idx                   = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cmd_scheduler.sv
// Grants one requester at a time round-robin, hands its command to the executor, reports done/timeout.
// Latency: grant one cycle after req seen in IDLE; min grant-to-grant spacing 3+GAP_CYCLES cycles.
// Backpressure: start held until executor drops ready; requests outside IDLE are ignored, not queued.
module cmd_scheduler
    import cmd_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int CMD_W      = 3,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CMD_W-1:0] req_cmd,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic [NREQ-1:0]       error,
    output logic [CMD_W-1:0]      command,
    output logic                  start,
    input  logic                  ready_command,
    output logic                  busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    // Terminal counts: a wait state aborts after TIMEOUT cycles, the gap lasts GAP_CYCLES cycles.
    localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);
    localparam logic [NREQ-1:0]      ONE_HOT0 = NREQ'(1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       win_q, win_d;
    logic [NREQ-1:0]        grant_q, grant_d;
    logic [NREQ-1:0]        done_q, done_d;
    logic [NREQ-1:0]        error_q, error_d;
    logic [CMD_W-1:0]       cmd_q, cmd_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic [NREQ-1:0]        arb_winner;
    logic [IDX_W-1:0]       arb_idx;
    logic [NREQ-1:0]        win_oh;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req    (req),
        .ptr    (ptr_q),
        .winner (arb_winner),
        .idx    (arb_idx)
    );

    assign win_oh = ONE_HOT0 << win_q;

    // Next-state and registered-output computation for the scheduler FSM.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        grant_d   = '0;
        done_d    = '0;
        error_d   = '0;
        cmd_d     = cmd_q;
        start_d   = start_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d  = ST_ISSUE;
                    grant_d  = arb_winner;
                    win_d    = arb_idx;
                    ptr_d    = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                    cmd_d    = req_cmd[arb_idx*CMD_W +: CMD_W];
                    start_d  = 1'b1;
                    to_cnt_d = '0;
                end
            end

            ST_ISSUE: begin
                if (!ready_command) begin
                    state_d  = ST_WAIT_DONE;
                    start_d  = 1'b0;
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    start_d  = 1'b0;
                    error_d  = win_oh;
                    to_cnt_d = '0;
                    // With no guard interval the scheduler is free again right away.
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                if (ready_command || (to_cnt_q == TO_LAST)) begin
                    if (ready_command) begin
                        done_d = win_oh;
                    end else begin
                        error_d = win_oh;
                    end
                    to_cnt_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset returns to IDLE with requester 0 first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            error_q   <= '0;
            cmd_q     <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            error_q   <= error_d;
            cmd_q     <= cmd_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign error   = error_q;
    assign command = cmd_q;
    assign start   = start_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed bench for cmd_scheduler: one instance with a guard gap, one with no gap.
// Latency: n/a.
// Backpressure: executor modelled as fast (ready = ~start), stuck-ready, or hand-driven.
module tb_cmd_scheduler;

    localparam int NREQ  = 4;
    localparam int CMD_W = 3;
    localparam int GAP   = 3;
    localparam int TMO   = 20;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*CMD_W-1:0] req_cmd;
    logic [NREQ-1:0]       grant, done, error;
    logic [CMD_W-1:0]      command;
    logic                  start, ready_command, busy;
    logic                  ready_man, fast_exec;

    logic [NREQ-1:0]       req_b;
    logic [NREQ*CMD_W-1:0] req_cmd_b;
    logic [NREQ-1:0]       grant_b, done_b, error_b;
    logic [CMD_W-1:0]      command_b;
    logic                  start_b, ready_b, busy_b;

    int errors = 0;
    int checks = 0;
    int viol = 0;
    int done_cnt = 0;

    assign ready_command = fast_exec ? ~start : ready_man;
    assign ready_b       = ~start_b;

    cmd_scheduler #(.NREQ(NREQ), .CMD_W(CMD_W), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd),
        .grant(grant), .done(done), .error(error), .command(command),
        .start(start), .ready_command(ready_command), .busy(busy)
    );

    cmd_scheduler #(.NREQ(NREQ), .CMD_W(CMD_W), .GAP_CYCLES(0), .TIMEOUT(TMO)) u_dut_nogap (
        .clk(clk), .rst(rst), .req(req_b), .req_cmd(req_cmd_b),
        .grant(grant_b), .done(done_b), .error(error_b), .command(command_b),
        .start(start_b), .ready_command(ready_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Pulse exclusivity monitor for both instances, plus done pulse tally.
    always @(negedge clk) begin
        if (!rst) begin
            if ((done != 0 && error != 0) || $countones(grant) > 1 ||
                $countones(done) > 1 || $countones(error) > 1) viol++;
            if ((done_b != 0 && error_b != 0) || $countones(grant_b) > 1 ||
                $countones(done_b) > 1 || $countones(error_b) > 1) viol++;
            if (done != 0) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 100), 32'd1);
    endtask

    function automatic int idx_of(input logic [NREQ-1:0] v);
        idx_of = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) idx_of = i;
    endfunction

    initial begin
        int n, got, last, d0, g;
        logic st_prev;

        rst       = 1'b1;
        req       = '0;
        req_cmd   = {3'b011, 3'b101, 3'b110, 3'b001};
        ready_man = 1'b1;
        fast_exec = 1'b0;
        req_b     = '0;
        req_cmd_b = {3'b111, 3'b010, 3'b100, 3'b000};

        // Reset state
        repeat (2) tick();
        check("rst_grant",   32'(grant),   32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_error",   32'(error),   32'd0);
        check("rst_start",   32'(start),   32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_command", 32'(command), 32'd0);
        check("rst_busy_b",  32'(busy_b),  32'd0);
        rst = 1'b0;
        repeat (3) tick();
        check("noreq_grant", 32'(grant), 32'd0);
        check("noreq_busy",  32'(busy),  32'd0);

        // Single request from 2, hand-driven executor
        req = 4'b0100;
        tick();
        check("t1_grant",   32'(grant),   32'h4);
        check("t1_command", 32'(command), 32'h5);
        check("t1_start",   32'(start),   32'd1);
        check("t1_busy",    32'(busy),    32'd1);
        req = '0;
        tick();
        check("t1_start_held", 32'(start), 32'd1);
        tick();
        ready_man = 1'b0;
        tick();
        check("t1_start_drop", 32'(start), 32'd0);
        check("t1_busy_wait",  32'(busy),  32'd1);
        repeat (3) tick();
        check("t1_no_early_done", 32'(done), 32'd0);
        ready_man = 1'b1;
        tick();
        check("t1_done",     32'(done),    32'h4);
        check("t1_no_error", 32'(error),   32'd0);
        check("t1_cmd_held", 32'(command), 32'h5);
        req = 4'b0100;
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == 0 && n < 50);
        check("t1_done_to_grant", 32'(n), 32'(GAP + 1));
        check("t1_regrant", 32'(grant), 32'h4);
        req = '0;
        fast_exec = 1'b1;
        wait_idle("t1_idle");

        // All requesting after reset: strict rotation, spacing 3+GAP
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d0 = done_cnt;
        req = 4'b1111;
        got = 0; last = 0; n = 0;
        while (got < 5 && n < 200) begin
            tick();
            n++;
            if (grant != 0) begin
                check($sformatf("t2_order%0d", got), 32'(idx_of(grant)), 32'(got % 4));
                if (got > 0) check($sformatf("t2_spacing%0d", got), 32'(n - last), 32'(3 + GAP));
                last = n;
                got++;
            end
        end
        req = '0;
        check("t2_grants", 32'(got), 32'd5);
        wait_idle("t2_idle");
        check("t2_dones", 32'(done_cnt - d0), 32'd5);

        // Executor never responds: timeout abort
        fast_exec = 1'b0;
        ready_man = 1'b1;
        req = 4'b0010;
        tick();
        check("t3_grant", 32'(grant), 32'h2);
        req = '0;
        d0 = done_cnt;
        n = 0;
        st_prev = 1'b0;
        while (error == 0 && n < 100) begin
            st_prev = start;
            tick();
            n++;
        end
        check("t3_latency",    32'(n),       32'(TMO));
        check("t3_error",      32'(error),   32'h2);
        check("t3_start_drop", 32'(start),   32'd0);
        check("t3_start_prev", 32'(st_prev), 32'd1);
        wait_idle("t3_idle");
        check("t3_no_done", 32'(done_cnt - d0), 32'd0);

        // Asynchronous reset in the middle of WAIT_DONE
        req = 4'b1001;
        tick();
        check("t4_grant", 32'(grant), 32'h8);
        ready_man = 1'b0;
        tick();
        tick();
        check("t4_busy_pre",  32'(busy),  32'd1);
        check("t4_start_pre", 32'(start), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("t4_async_busy",    32'(busy),    32'd0);
        check("t4_async_command", 32'(command), 32'd0);
        check("t4_async_pulses",  32'({grant, done, error}), 32'd0);
        check("t4_async_start",   32'(start),   32'd0);
        tick();
        rst = 1'b0;
        ready_man = 1'b1;
        tick();
        check("t4_rr_after_reset", 32'(grant), 32'h1);
        req = '0;
        fast_exec = 1'b1;
        wait_idle("t4_idle");

        // Request that lives only inside GAP is ignored
        req = 4'b0001;
        tick();
        check("t5_grant", 32'(grant), 32'h1);
        req = '0;
        n = 0;
        while (done == 0 && n < 20) begin
            tick();
            n++;
        end
        check("t5_done_latency", 32'(n), 32'd2);
        req = 4'b1000;
        tick();
        tick();
        req = '0;
        g = 0;
        repeat (20) begin
            tick();
            if (grant != 0) g++;
        end
        check("t5_no_grant", 32'(g), 32'd0);
        check("t5_busy",     32'(busy), 32'd0);

        // Zero guard gap: grants every 3 cycles with a 1-cycle executor
        req_b = 4'b0010;
        g = 0; n = 0; last = 0;
        while (g < 4 && n < 100) begin
            tick();
            n++;
            if (grant_b != 0) begin
                check($sformatf("t6_grant%0d", g), 32'(grant_b), 32'h2);
                check($sformatf("t6_cmd%0d", g), 32'(command_b), 32'h4);
                if (g > 0) check($sformatf("t6_spacing%0d", g), 32'(n - last), 32'd3);
                last = n;
                g++;
            end
        end
        req_b = '0;
        check("t6_grants", 32'(g), 32'd4);

        check("pulse_exclusive", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
